mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath. Sequences instruction fetch, decode, execute, memory access and write-back by driving every datapath enable and mux select: PC, IR, register file, ALU, memory and PC source. Supports lw, sw, R-type, beq, j and addi. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

---
 rtl/mips_pkg.sv | 62 ++++++
 rtl/mips_multicycle_ctrl_if.sv | 41 ++++
 rtl/mips_ctrl_decode.sv | 75 +++++++
 rtl/mips_multicycle_ctrl.sv | 90 +++++++++
 tb/tb_mips_multicycle_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS main controller.
//   - opcode constants for the supported instructions
//   - controller state enum (4-bit, also exported on the debug state port)
//   - ALU_OP, ALU_SRC_B and PC_SRC mux encodings
//   - ctrl_t: bundle of every datapath enable / select the controller drives
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ALU_SRC_B_REG  = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR = 2'b01;
    localparam logic [1:0] ALU_SRC_B_SEXT = 2'b10;
    localparam logic [1:0] ALU_SRC_B_SH2  = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: controller <-> datapath/memory signal bundle.
//   master modport: the controller (drives enables/selects, reads opcode/mem_ready)
//   slave modport : the datapath and memory side
// Handshake: mem_read/mem_write are held high for as long as the access is
// outstanding; the access completes in the cycle where mem_ready is also 1,
// and the controller leaves the access state on that clock edge.
interface mips_multicycle_ctrl_if #(
    parameter int OP_W = 6
);
    logic [OP_W-1:0] opcode;
    logic            mem_ready;
    logic            pc_write;
    logic            pc_write_cond;
    logic            i_or_d;
    logic            mem_read;
    logic            mem_write;
    logic            ir_write;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      alu_op;
    logic [1:0]      pc_source;
    logic            illegal_op;
    logic [3:0]      state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );
endinterface

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: purely combinational Moore decode of the controller state
// into datapath controls. mem_ready only gates ir_write/pc_write in FETCH.
//   i_state     : current controller state
//   i_mem_ready : memory completed the access this cycle
//   o_ctrl      : all datapath enables and mux selects
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_NONE;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = ALU_SRC_B_FOUR;
                o_ctrl.alu_op    = ALU_OP_ADD;
                o_ctrl.pc_source = PC_SRC_ALU;
                // IR and PC load only once the instruction word is actually there.
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                o_ctrl.alu_src_b = ALU_SRC_B_SH2;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALU_SRC_B_SEXT;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_READ: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALU_SRC_B_REG;
                o_ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_ALU_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = ALU_SRC_B_REG;
                o_ctrl.alu_op        = ALU_OP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PC_SRC_JUMP;
            end
            S_ADDI_WB: begin
                o_ctrl.reg_write = 1'b1;
            end
            default: o_ctrl = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the multicycle MIPS datapath.
// Supports lw, sw, R-type, beq, j, addi; stalls in FETCH/MEM_READ/MEM_WRITE
// until mem_ready.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (forces IDLE, all strobes low)
//   bus   : master side of mips_multicycle_ctrl_if (opcode/mem_ready in,
//           all datapath controls, illegal_op and debug state out)
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mips_multicycle_ctrl_if.master        bus
);

    state_t          r_state;
    state_t          w_next;
    logic            w_illegal;
    ctrl_t           w_ctrl;
    logic [OP_W-1:0] w_opcode;

    assign w_opcode = bus.opcode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // opcode is looked at only in DECODE and MEM_ADDR.
    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            S_IDLE:      w_next = S_FETCH;
            S_FETCH:     w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EXEC;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR:  w_next = (w_opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_next = S_FETCH;
            S_MEM_WRITE: w_next = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   w_next = S_ALU_WB;
            S_ALU_WB:    w_next = S_FETCH;
            S_BRANCH:    w_next = S_FETCH;
            S_JUMP:      w_next = S_FETCH;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            S_ADDI_WB:   w_next = S_FETCH;
            default:     w_next = S_IDLE;
        endcase
    end

    mips_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (bus.mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign bus.pc_write      = w_ctrl.pc_write;
    assign bus.pc_write_cond = w_ctrl.pc_write_cond;
    assign bus.i_or_d        = w_ctrl.i_or_d;
    assign bus.mem_read      = w_ctrl.mem_read;
    assign bus.mem_write     = w_ctrl.mem_write;
    assign bus.ir_write      = w_ctrl.ir_write;
    assign bus.reg_dst       = w_ctrl.reg_dst;
    assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
    assign bus.reg_write     = w_ctrl.reg_write;
    assign bus.alu_src_a     = w_ctrl.alu_src_a;
    assign bus.alu_src_b     = w_ctrl.alu_src_b;
    assign bus.alu_op        = w_ctrl.alu_op;
    assign bus.pc_source     = w_ctrl.pc_source;
    assign bus.illegal_op    = w_illegal;
    assign bus.state         = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    // Control word layout used by this bench:
    // [16] pc_write [15] pc_write_cond [14] i_or_d [13] mem_read [12] mem_write
    // [11] ir_write [10] reg_dst [9] mem_to_reg [8] reg_write [7] alu_src_a
    // [6:5] alu_src_b [4:3] alu_op [2:1] pc_source [0] illegal_op
    localparam logic [16:0] C_NONE      = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_FETCH_RDY = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FETCH_WT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DEC       = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_DEC_ILL   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] C_MADDR     = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MREAD     = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MWB       = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_MWRITE    = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_EXEC      = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_ALUWB     = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] C_BRANCH    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_JUMP      = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] C_ADDIWB    = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
                           ST_MADDR = 4'd3, ST_MREAD = 4'd4, ST_MWB = 4'd5,
                           ST_MWRITE = 4'd6, ST_EXEC = 4'd7, ST_ALUWB = 4'd8,
                           ST_BRANCH = 4'd9, ST_JUMP = 4'd10, ST_AEXEC = 4'd11,
                           ST_AWB = 4'd12;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctl;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.OP_W(6)) bus ();

    mips_multicycle_ctrl #(.OP_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [16:0] w_act;
    assign w_act = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                    bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                    bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                    bus.pc_source, bus.illegal_op};

    // ---------------- scoreboard ----------------
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [5:0] op, input logic rdy,
                           input logic [3:0] st, input logic [16:0] ctl);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl;
        vecs.push_back(v);
    endtask

    task automatic check_rules(input string tag);
        check({tag, " rd&wr"}, {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
        if (bus.state != ST_FETCH)
            check({tag, " onehot-wr"},
                  {31'd0, (32'(bus.reg_write) + 32'(bus.pc_write) + 32'(bus.pc_write_cond)) > 1}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b1;

        // lw, zero wait (5 cycles)
        add_vec(6'h23, 1'b1, ST_IDLE,   C_NONE);
        add_vec(6'h23, 1'b1, ST_FETCH,  C_FETCH_RDY);
        add_vec(6'h23, 1'b1, ST_DECODE, C_DEC);
        add_vec(6'h23, 1'b1, ST_MADDR,  C_MADDR);
        add_vec(6'h23, 1'b1, ST_MREAD,  C_MREAD);
        add_vec(6'h23, 1'b1, ST_MWB,    C_MWB);
        // sw with 3 wait cycles in MEM_WRITE
        add_vec(6'h2B, 1'b1, ST_FETCH,  C_FETCH_RDY);
        add_vec(6'h2B, 1'b1, ST_DECODE, C_DEC);
        add_vec(6'h2B, 1'b1, ST_MADDR,  C_MADDR);
        add_vec(6'h2B, 1'b0, ST_MWRITE, C_MWRITE);
        add_vec(6'h2B, 1'b0, ST_MWRITE, C_MWRITE);
        add_vec(6'h2B, 1'b0, ST_MWRITE, C_MWRITE);
        add_vec(6'h2B, 1'b1, ST_MWRITE, C_MWRITE);
        // R-type with one fetch stall
        add_vec(6'h00, 1'b0, ST_FETCH,  C_FETCH_WT);
        add_vec(6'h00, 1'b1, ST_FETCH,  C_FETCH_RDY);
        add_vec(6'h00, 1'b1, ST_DECODE, C_DEC);
        add_vec(6'h00, 1'b1, ST_EXEC,   C_EXEC);
        add_vec(6'h00, 1'b1, ST_ALUWB,  C_ALUWB);
        // beq, j (3 cycles each)
        add_vec(6'h04, 1'b1, ST_FETCH,  C_FETCH_RDY);
        add_vec(6'h04, 1'b1, ST_DECODE, C_DEC);
        add_vec(6'h04, 1'b1, ST_BRANCH, C_BRANCH);
        add_vec(6'h02, 1'b1, ST_FETCH,  C_FETCH_RDY);
        add_vec(6'h02, 1'b1, ST_DECODE, C_DEC);
        add_vec(6'h02, 1'b1, ST_JUMP,   C_JUMP);
        // addi; opcode changes after DECODE must be ignored
        add_vec(6'h08, 1'b1, ST_FETCH,  C_FETCH_RDY);
        add_vec(6'h08, 1'b1, ST_DECODE, C_DEC);
        add_vec(6'h3F, 1'b1, ST_AEXEC,  C_MADDR);
        add_vec(6'h3F, 1'b1, ST_AWB,    C_ADDIWB);
        // illegal opcode (2 cycles)
        add_vec(6'h3F, 1'b1, ST_FETCH,  C_FETCH_RDY);
        add_vec(6'h3F, 1'b1, ST_DECODE, C_DEC_ILL);
        // lw with one wait cycle in MEM_READ
        add_vec(6'h23, 1'b1, ST_FETCH,  C_FETCH_RDY);
        add_vec(6'h23, 1'b1, ST_DECODE, C_DEC);
        add_vec(6'h23, 1'b1, ST_MADDR,  C_MADDR);
        add_vec(6'h23, 1'b0, ST_MREAD,  C_MREAD);
        add_vec(6'h23, 1'b1, ST_MREAD,  C_MREAD);
        add_vec(6'h23, 1'b1, ST_MWB,    C_MWB);
        add_vec(6'h23, 1'b1, ST_FETCH,  C_FETCH_RDY);

        // Reset state while rst_n is held low
        #3;
        check("reset state", {28'd0, bus.state}, {28'd0, ST_IDLE});
        check("reset ctrl",  {15'd0, w_act}, {15'd0, C_NONE});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven walk: inputs applied at negedge, sampled 1 ns later
        for (int i = 0; i < vecs.size(); i++) begin
            bus.opcode    = vecs[i].op;
            bus.mem_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d state", i), {28'd0, bus.state}, {28'd0, vecs[i].st});
            check($sformatf("vec%0d ctrl", i),  {15'd0, w_act}, {15'd0, vecs[i].ctl});
            check_rules($sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Now in DECODE; run sw into MEM_WRITE and reset mid-access.
        bus.opcode    = 6'h2B;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("rst seq maddr", {28'd0, bus.state}, {28'd0, ST_MADDR});
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("rst seq mwrite state", {28'd0, bus.state}, {28'd0, ST_MWRITE});
        check("rst seq mem_write on", {31'd0, bus.mem_write}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst mem_write", {31'd0, bus.mem_write}, 32'd0);
        check("async rst state",     {28'd0, bus.state}, {28'd0, ST_IDLE});
        check("async rst ctrl",      {15'd0, w_act}, {15'd0, C_NONE});
        @(negedge clk);
        check("held rst state", {28'd0, bus.state}, {28'd0, ST_IDLE});
        rst_n         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'h04;
        #1;
        check("post rst idle", {28'd0, bus.state}, {28'd0, ST_IDLE});
        @(negedge clk);
        check("post rst fetch state", {28'd0, bus.state}, {28'd0, ST_FETCH});
        check("post rst fetch ctrl",  {15'd0, w_act}, {15'd0, C_FETCH_RDY});
        @(negedge clk);
        check("post rst decode", {28'd0, bus.state}, {28'd0, ST_DECODE});
        @(negedge clk);
        check("post rst branch", {28'd0, bus.state}, {28'd0, ST_BRANCH});
        check("post rst branch ctrl", {15'd0, w_act}, {15'd0, C_BRANCH});

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
